bfly_pipe: RTL and testbench

//  Pipelined, parametrised radix-2 complex butterfly for the 32-point FFT datapath.

---
 rtl/bfly_pipe.sv | 177 +++++++++++++++++
 tb/tb_bfly_pipe.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bfly_pipe.sv
// Three-stage pipelined radix-2 complex butterfly (DIT/DIF, optional 1/2 scaling) with valid/ready flow.
// Define BFLY_SAT_EN to clamp final components and drive ovf; otherwise results wrap and ovf stays 0.
module bfly_pipe #(
    parameter int BITS    = 16,
    parameter int FIX_BIT = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*BITS-1:0] in0,
    input  logic [2*BITS-1:0] in1,
    input  logic [2*BITS-1:0] tw,
    input  logic              mode,
    input  logic              scale,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*BITS-1:0] out0,
    output logic [2*BITS-1:0] out1,
    output logic              ovf
);

    localparam int AW = BITS + 1;
    localparam int MW = 2*BITS + 3;
    localparam int PW = MW - FIX_BIT;
    localparam int SW = PW + 1;
    localparam logic signed [MW-1:0] RND = MW'(1) << (FIX_BIT - 1);
`ifdef BFLY_SAT_EN
    localparam logic signed [SW-1:0] SMAX = SW'((2**(BITS-1)) - 1);
    localparam logic signed [SW-1:0] SMIN = ~SMAX;
`endif

    logic adv;

    assign in_ready = ~(out_valid & ~out_ready);
    assign adv      = in_ready;

    // stage 1: operand split and optional DIF pre-add
    logic signed [AW-1:0] x0_re, x0_im, x1_re, x1_im;
    logic                 s1_valid, s1_mode, s1_scale;
    logic signed [AW-1:0] s1_a_re, s1_a_im, s1_b_re, s1_b_im;
    logic signed [BITS-1:0] s1_w_re, s1_w_im;

    assign x0_re = {in0[BITS-1], in0[BITS-1:0]};
    assign x0_im = {in0[2*BITS-1], in0[2*BITS-1:BITS]};
    assign x1_re = {in1[BITS-1], in1[BITS-1:0]};
    assign x1_im = {in1[2*BITS-1], in1[2*BITS-1:BITS]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_mode  <= 1'b0;
            s1_scale <= 1'b0;
            s1_a_re  <= '0;
            s1_a_im  <= '0;
            s1_b_re  <= '0;
            s1_b_im  <= '0;
            s1_w_re  <= '0;
            s1_w_im  <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_mode  <= mode;
            s1_scale <= scale;
            s1_a_re  <= mode ? x0_re + x1_re : x0_re;
            s1_a_im  <= mode ? x0_im + x1_im : x0_im;
            s1_b_re  <= mode ? x0_re - x1_re : x1_re;
            s1_b_im  <= mode ? x0_im - x1_im : x1_im;
            s1_w_re  <= tw[BITS-1:0];
            s1_w_im  <= tw[2*BITS-1:BITS];
        end
    end

    // stage 2: complex multiply, one rounding per component
    function automatic logic signed [MW-1:0] ext_b(input logic signed [AW-1:0] v);
        return {{(MW-AW){v[AW-1]}}, v};
    endfunction

    function automatic logic signed [MW-1:0] ext_w(input logic signed [BITS-1:0] v);
        return {{(MW-BITS){v[BITS-1]}}, v};
    endfunction

    logic signed [MW-1:0] br, bi, wr, wi, m_re, m_im;
    logic                 s2_valid, s2_mode, s2_scale;
    logic signed [AW-1:0] s2_a_re, s2_a_im;
    logic signed [PW-1:0] s2_p_re, s2_p_im;

    assign br   = ext_b(s1_b_re);
    assign bi   = ext_b(s1_b_im);
    assign wr   = ext_w(s1_w_re);
    assign wi   = ext_w(s1_w_im);
    assign m_re = br*wr - bi*wi + RND;
    assign m_im = br*wi + bi*wr + RND;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_mode  <= 1'b0;
            s2_scale <= 1'b0;
            s2_a_re  <= '0;
            s2_a_im  <= '0;
            s2_p_re  <= '0;
            s2_p_im  <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_mode  <= s1_mode;
            s2_scale <= s1_scale;
            s2_a_re  <= s1_a_re;
            s2_a_im  <= s1_a_im;
            s2_p_re  <= m_re[MW-1:FIX_BIT];
            s2_p_im  <= m_im[MW-1:FIX_BIT];
        end
    end

    // stage 3: post-add, optional halving, then clamp or wrap to BITS
    function automatic logic signed [SW-1:0] scl(input logic signed [SW-1:0] v, input logic en);
        logic signed [SW-1:0] t;
        t = v + SW'(1);
        return en ? (t >>> 1) : v;
    endfunction

    function automatic logic [BITS:0] fit(input logic signed [SW-1:0] v);
        logic [BITS:0] r;
`ifdef BFLY_SAT_EN
        if (v > SMAX)
            r = {1'b1, SMAX[BITS-1:0]};
        else if (v < SMIN)
            r = {1'b1, SMIN[BITS-1:0]};
        else
            r = {1'b0, v[BITS-1:0]};
`else
        r = {1'b0, v[BITS-1:0]};
`endif
        return r;
    endfunction

    logic signed [SW-1:0] a_re_x, a_im_x, p_re_x, p_im_x;
    logic signed [SW-1:0] y0_re, y0_im, y1_re, y1_im;
    logic [BITS:0]        f0_re, f0_im, f1_re, f1_im;

    assign a_re_x = {{(SW-AW){s2_a_re[AW-1]}}, s2_a_re};
    assign a_im_x = {{(SW-AW){s2_a_im[AW-1]}}, s2_a_im};
    assign p_re_x = {s2_p_re[PW-1], s2_p_re};
    assign p_im_x = {s2_p_im[PW-1], s2_p_im};

    always_comb begin
        y0_re = a_re_x;
        y0_im = a_im_x;
        y1_re = p_re_x;
        y1_im = p_im_x;
        if (!s2_mode) begin
            y0_re = a_re_x + p_re_x;
            y0_im = a_im_x + p_im_x;
            y1_re = a_re_x - p_re_x;
            y1_im = a_im_x - p_im_x;
        end
    end

    assign f0_re = fit(scl(y0_re, s2_scale));
    assign f0_im = fit(scl(y0_im, s2_scale));
    assign f1_re = fit(scl(y1_re, s2_scale));
    assign f1_im = fit(scl(y1_im, s2_scale));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out0      <= '0;
            out1      <= '0;
            ovf       <= 1'b0;
        end else if (adv) begin
            out_valid <= s2_valid;
            out0      <= {f0_im[BITS-1:0], f0_re[BITS-1:0]};
            out1      <= {f1_im[BITS-1:0], f1_re[BITS-1:0]};
            ovf       <= f0_re[BITS] | f0_im[BITS] | f1_re[BITS] | f1_im[BITS];
        end
    end

endmodule

// File: tb/tb_bfly_pipe.sv
// Self-checking bench for bfly_pipe: directed vectors, stall/throughput streams, random traffic, mid-run reset.
// Build with BFLY_SAT_EN defined to check the clamping variant.
module tb_bfly_pipe;
    localparam int BITS    = 16;
    localparam int FIX_BIT = 7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, in_ready, mode, scale, out_valid, out_ready, ovf;
    logic [31:0] in0, in1, tw, out0, out1;

    always #5 clk = ~clk;

    bfly_pipe #(.BITS(BITS), .FIX_BIT(FIX_BIT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in0(in0), .in1(in1), .tw(tw), .mode(mode), .scale(scale),
        .out_valid(out_valid), .out_ready(out_ready),
        .out0(out0), .out1(out1), .ovf(ovf)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic        ovf;
        logic [31:0] o1;
        logic [31:0] o0;
    } res_t;

    res_t sbq[$];

    function automatic logic [31:0] cx(input int re, input int im);
        logic [31:0] r;
        r = {im[15:0], re[15:0]};
        return r;
    endfunction

    function automatic longint cre(input logic [31:0] v);
        return longint'($signed(v[15:0]));
    endfunction

    function automatic longint cim(input logic [31:0] v);
        return longint'($signed(v[31:16]));
    endfunction

    function automatic longint rnd(input longint x);
        return (x + 64) >>> 7;
    endfunction

    function automatic logic [16:0] fin(input longint x, input logic sc);
        longint y;
        y = sc ? ((x + 1) >>> 1) : x;
`ifdef BFLY_SAT_EN
        if (y > 32767)  return {1'b1, 16'h7fff};
        if (y < -32768) return {1'b1, 16'h8000};
`endif
        return {1'b0, y[15:0]};
    endfunction

    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic [31:0] w,
                                   input logic m, input logic sc);
        longint ar, ai, br, bi, wr, wi, dr, di, pr, pi, x0r, x0i, x1r, x1i;
        logic [16:0] f0r, f0i, f1r, f1i;
        res_t r;
        ar = cre(a); ai = cim(a); br = cre(b); bi = cim(b); wr = cre(w); wi = cim(w);
        if (m) begin
            dr = ar - br; di = ai - bi;
            pr = rnd(dr*wr - di*wi); pi = rnd(dr*wi + di*wr);
            x0r = ar + br; x0i = ai + bi; x1r = pr; x1i = pi;
        end else begin
            pr = rnd(br*wr - bi*wi); pi = rnd(br*wi + bi*wr);
            x0r = ar + pr; x0i = ai + pi; x1r = ar - pr; x1i = ai - pi;
        end
        f0r = fin(x0r, sc); f0i = fin(x0i, sc); f1r = fin(x1r, sc); f1i = fin(x1i, sc);
        r.o0  = {f0i[15:0], f0r[15:0]};
        r.o1  = {f1i[15:0], f1r[15:0]};
        r.ovf = f0r[16] | f0i[16] | f1r[16] | f1i[16];
        return r;
    endfunction

    int cyc = 0;
    int n_in = 0;
    int n_out = 0;
    int first_out = -1;
    int last_out = -1;

    always @(posedge clk) cyc++;

    // scoreboard: pop on output transfer, push on input transfer
    always @(negedge clk) begin
        res_t e;
        if (rst_n) begin
            check("in_ready_rule", in_ready, !(out_valid && !out_ready));
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    check("sb_unexpected_out", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check("out0", out0, e.o0);
                    check("out1", out1, e.o1);
                    check("ovf", ovf, e.ovf);
                end
                n_out++;
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
            end
            if (in_valid && in_ready) begin
                sbq.push_back(model(in0, in1, tw, mode, scale));
                n_in++;
            end
        end
    end

    task automatic set_rand();
        if ($urandom_range(1) == 1) begin
            in0 = cx(int'($urandom_range(400)) - 200, int'($urandom_range(400)) - 200);
            in1 = cx(int'($urandom_range(400)) - 200, int'($urandom_range(400)) - 200);
            tw  = cx(int'($urandom_range(256)) - 128, int'($urandom_range(256)) - 128);
        end else begin
            in0 = $urandom;
            in1 = $urandom;
            tw  = $urandom;
        end
        mode  = 1'($urandom_range(1));
        scale = 1'($urandom_range(1));
    endtask

    // called #1 after a rising edge with an empty pipe
    task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic [31:0] w,
                           input logic m, input logic sc,
                           input logic [31:0] e0, input logic [31:0] e1, input logic eo,
                           input string tag);
        in0 = a; in1 = b; tw = w; mode = m; scale = sc;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1 check({tag, "_lat2"}, out_valid, 1'b0);
        @(posedge clk); #1 check({tag, "_lat3"}, out_valid, 1'b1);
        check({tag, "_out0"}, out0, e0);
        check({tag, "_out1"}, out1, e1);
        check({tag, "_ovf"}, ovf, eo);
        @(posedge clk); #1;
    endtask

    task automatic stream(input int n, input bit stall);
        int   idx;
        int   k;
        logic acc;
        idx = 0; k = 0;
        set_rand();
        in_valid = 1'b1;
        while ((idx < n || sbq.size() > 0) && k < 200) begin
            out_ready = stall ? !(k >= 4 && k <= 8) : 1'b1;
            @(negedge clk);
            acc = in_valid && in_ready;
            if (stall && k >= 5 && k <= 8) check("stall_in_ready", in_ready, 1'b0);
            @(posedge clk); #1;
            k++;
            if (acc) begin
                idx++;
                if (idx < n) set_rand();
                else in_valid = 1'b0;
            end
        end
        check("stream_done", (idx == n && sbq.size() == 0), 1'b1);
        in_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        int k;
        in_valid = 1'b0; out_ready = 1'b1; mode = 1'b0; scale = 1'b0;
        in0 = '0; in1 = '0; tw = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out0", out0, 32'd0);
        check("rst_out1", out1, 32'd0);
        check("rst_ovf", ovf, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_one(cx(100, 0), cx(50, 0), cx(128, 0), 1'b0, 1'b0, cx(150, 0), cx(50, 0), 1'b0, "t1");
        run_one(cx(0, 0), cx(64, 32), cx(0, -128), 1'b0, 1'b0, cx(32, -64), cx(-32, 64), 1'b0, "t2");
        run_one(cx(0, 0), cx(64, 32), cx(0, -128), 1'b0, 1'b1, cx(16, -32), cx(-16, 32), 1'b0, "t2s");
        run_one(cx(100, 0), cx(50, 0), cx(0, -128), 1'b1, 1'b0, cx(150, 0), cx(0, -50), 1'b0, "t3");
`ifdef BFLY_SAT_EN
        run_one(cx(32767, 0), cx(32767, 0), cx(128, 0), 1'b0, 1'b0, cx(32767, 0), cx(0, 0), 1'b1, "t4");
`else
        run_one(cx(32767, 0), cx(32767, 0), cx(128, 0), 1'b0, 1'b0, cx(-2, 0), cx(0, 0), 1'b0, "t4");
`endif

        stream(8, 1'b1);
        first_out = -1;
        stream(8, 1'b0);
        check("throughput_span", last_out - first_out, 7);

        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            set_rand();
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        k = 0;
        while (sbq.size() > 0 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("random_drain", sbq.size(), 0);

        // reset with samples in flight and one held at the output
        out_ready = 1'b0;
        set_rand(); in_valid = 1'b1;
        @(posedge clk); #1 set_rand();
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_out0", out0, 32'd0);
        check("mid_rst_out1", out1, 32'd0);
        check("mid_rst_ovf", ovf, 1'b0);
        n_in -= sbq.size();
        sbq.delete();
        out_ready = 1'b1;
        @(posedge clk); #3 rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk); #1 check("post_rst_idle", out_valid, 1'b0);
        end
        run_one(cx(100, 0), cx(50, 0), cx(128, 0), 1'b0, 1'b0, cx(150, 0), cx(50, 0), 1'b0, "t6r");

        check("sb_empty", sbq.size(), 0);
        check("in_out_count", n_out, n_in);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
